// File: rtl/magia_tile_pkg.sv
// magia_tile_pkg: RedMulE control offsets, HWPE-ctrl port types and sequencer states
package magia_tile_pkg;

    localparam logic [31:0] REDMULE_TRIGGER  = 32'h0000_0000;
    localparam logic [31:0] REDMULE_ACQUIRE  = 32'h0000_0004;
    localparam logic [31:0] REDMULE_JOB_BASE = 32'h0000_0040;
    localparam int          REDMULE_ID_W     = 8;

    typedef enum logic [3:0] {
        IDLE,
        ACQ_REQ,
        ACQ_RSP,
        WR_REQ,
        WR_RSP,
        TRIG_REQ,
        TRIG_RSP,
        WAIT_EVT,
        DONE,
        ERR
    } redmule_seq_state_e;

    typedef struct packed {
        logic                    req;
        logic [31:0]             add;
        logic [31:0]             data;
        logic [3:0]              be;
        logic                    wen;
        logic [REDMULE_ID_W-1:0] id;
    } redmule_ctrl_req_t;

    typedef struct packed {
        logic        gnt;
        logic        r_valid;
        logic [31:0] r_data;
    } redmule_ctrl_rsp_t;

endpackage

// File: rtl/redmule_job_sequencer.sv
// redmule_job_sequencer: acquires a RedMulE slot, programs the job registers, triggers and waits for completion
module redmule_job_sequencer
    import magia_tile_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 8,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned MAX_ACQ_RETRY = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [NUM_REGS-1:0][31:0] job_regs_i,
    output redmule_ctrl_req_t        ctrl_req_o,
    input  redmule_ctrl_rsp_t        ctrl_rsp_i,
    input  logic                     evt_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [7:0]               job_id_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    redmule_seq_state_e        r_state, w_next;
    logic [NUM_REGS-1:0][31:0] r_regs;
    logic [IDX_W-1:0]          r_idx;
    logic [7:0]                r_retry;
    logic                      r_evt;
    logic [7:0]                r_job_id;
    logic                      w_accept, w_evt_set, w_evt, w_last, w_acq_ok;
    logic [7:0]                w_retry_inc;

    assign w_accept    = (r_state == IDLE) && job_valid_i;
    assign w_evt_set   = evt_i && ((r_state == TRIG_REQ && ctrl_rsp_i.gnt) || r_state == TRIG_RSP || r_state == WAIT_EVT);
    assign w_evt       = r_evt || w_evt_set;
    assign w_last      = r_idx == IDX_W'(NUM_REGS - 1);
    assign w_acq_ok    = $signed(ctrl_rsp_i.r_data) >= 0;
    assign w_retry_inc = r_retry + 8'd1;

    assign job_ready_o = r_state == IDLE;
    assign busy_o      = r_state != IDLE;
    assign done_o      = r_state == DONE;
    assign err_o       = r_state == ERR;
    assign job_id_o    = r_job_id;

    // state register
    always_ff @(posedge clk_i) begin
        r_state <= !rst_ni ? IDLE : w_next;
    end

    // next state and the HWPE-ctrl request, which is a pure function of the state
    always_comb begin
        w_next     = r_state;
        ctrl_req_o = '0;
        case (r_state)
            IDLE:     w_next = job_valid_i ? ACQ_REQ : IDLE;
            ACQ_REQ: begin
                ctrl_req_o.req = 1'b1;
                ctrl_req_o.add = BASE_ADDR + REDMULE_ACQUIRE;
                ctrl_req_o.be  = 4'hF;
                ctrl_req_o.wen = 1'b1;
                w_next         = ctrl_rsp_i.gnt ? ACQ_RSP : ACQ_REQ;
            end
            ACQ_RSP:  w_next = !ctrl_rsp_i.r_valid ? ACQ_RSP :
                               w_acq_ok ? WR_REQ :
                               (w_retry_inc == 8'(MAX_ACQ_RETRY)) ? ERR : ACQ_REQ;
            WR_REQ: begin
                ctrl_req_o.req  = 1'b1;
                ctrl_req_o.add  = BASE_ADDR + REDMULE_JOB_BASE + 32'({r_idx, 2'b00});
                ctrl_req_o.data = r_regs[r_idx];
                ctrl_req_o.be   = 4'hF;
                w_next          = ctrl_rsp_i.gnt ? WR_RSP : WR_REQ;
            end
            WR_RSP:   w_next = !ctrl_rsp_i.r_valid ? WR_RSP : (w_last ? TRIG_REQ : WR_REQ);
            TRIG_REQ: begin
                ctrl_req_o.req = 1'b1;
                ctrl_req_o.add = BASE_ADDR + REDMULE_TRIGGER;
                ctrl_req_o.be  = 4'hF;
                w_next         = ctrl_rsp_i.gnt ? TRIG_RSP : TRIG_REQ;
            end
            TRIG_RSP: w_next = ctrl_rsp_i.r_valid ? WAIT_EVT : TRIG_RSP;
            WAIT_EVT: w_next = w_evt ? DONE : WAIT_EVT;
            default:  w_next = IDLE;
        endcase
    end

    // descriptor latch, acquire retry/ID, write index and sticky completion flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_regs   <= '0;
            r_idx    <= '0;
            r_retry  <= '0;
            r_evt    <= 1'b0;
            r_job_id <= '0;
        end else begin
            if (w_accept) begin
                r_regs  <= job_regs_i;
                r_idx   <= '0;
                r_retry <= '0;
            end
            if (r_state == ACQ_RSP && ctrl_rsp_i.r_valid) begin
                if (w_acq_ok) r_job_id <= ctrl_rsp_i.r_data[7:0];
                else          r_retry  <= w_retry_inc;
            end
            if (r_state == WR_RSP && ctrl_rsp_i.r_valid && !w_last) r_idx <= r_idx + 1'b1;
            r_evt <= w_accept ? 1'b0 : w_evt;
        end
    end

endmodule

// File: tb/tb_redmule_job_sequencer.sv
// tb_redmule_job_sequencer: randomized job scenarios against a transaction-level model of the sequencer
module tb_redmule_job_sequencer;
    import magia_tile_pkg::*;

    localparam int NUM_REGS  = 8;
    localparam int MAX_RETRY = 4;

    logic                      clk_i = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      job_valid = 1'b0;
    logic                      job_ready_o;
    logic [NUM_REGS-1:0][31:0] job_regs = '0;
    redmule_ctrl_req_t         ctrl_req;
    redmule_ctrl_rsp_t         ctrl_rsp;
    logic                      evt = 1'b0;
    logic                      busy_o, done_o, err_o;
    logic [7:0]                job_id_o;

    int checks = 0, passes = 0;
    int done_cnt = 0, err_cnt = 0;
    int gnt_max = 0, rv_min = 1, rv_max = 1;
    bit noise_evt = 1'b0;
    logic [31:0]       acq_q[$];
    logic [31:0]       cur_acq[$];
    logic [31:0]       cur_regs[NUM_REGS];
    redmule_ctrl_req_t log_q[$];

    redmule_job_sequencer #(
        .NUM_REGS(NUM_REGS),
        .BASE_ADDR(32'h0),
        .MAX_ACQ_RETRY(MAX_RETRY)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_n),
        .job_valid_i(job_valid),
        .job_ready_o(job_ready_o),
        .job_regs_i(job_regs),
        .ctrl_req_o(ctrl_req),
        .ctrl_rsp_i(ctrl_rsp),
        .evt_i(evt),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .job_id_o(job_id_o)
    );

    always #5 clk_i = ~clk_i;

    // count completion and error cycles
    always @(posedge clk_i) begin
        if (done_o === 1'b1) done_cnt++;
        if (err_o === 1'b1) err_cnt++;
    end

    // HWPE-ctrl slave: random grant and response delays, checks request stability while stalled
    initial begin : responder
        redmule_ctrl_req_t held;
        int d;
        ctrl_rsp = '0;
        forever begin
            @(negedge clk_i);
            ctrl_rsp = '0;
            if (ctrl_req.req === 1'b1) begin
                held = ctrl_req;
                d = $urandom_range(gnt_max, 0);
                repeat (d) begin
                    @(negedge clk_i);
                    checks++;
                    if (ctrl_req !== held)
                        $display("FAIL req_stable: got req=%b add=%h data=%h wen=%b, want req=1 add=%h data=%h wen=%b",
                                 ctrl_req.req, ctrl_req.add, ctrl_req.data, ctrl_req.wen, held.add, held.data, held.wen);
                    else passes++;
                end
                ctrl_rsp.gnt = 1'b1;
                log_q.push_back(held);
                d = $urandom_range(rv_max, rv_min);
                repeat (d) begin
                    @(negedge clk_i);
                    ctrl_rsp = '0;
                end
                ctrl_rsp.r_valid = 1'b1;
                ctrl_rsp.r_data  = $urandom();
                if (held.wen && held.add == 32'h04) ctrl_rsp.r_data = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

    function automatic redmule_ctrl_req_t mk(input logic [31:0] a, input logic [31:0] d, input logic w);
        mk      = '0;
        mk.req  = 1'b1;
        mk.add  = a;
        mk.data = d;
        mk.be   = 4'hF;
        mk.wen  = w;
    endfunction

    function automatic logic [31:0] rnd_neg();
        return $urandom() | 32'h8000_0000;
    endfunction

    function automatic logic [31:0] rnd_pos();
        return $urandom() & 32'h7FFF_FFFF;
    endfunction

    // issue one job from cur_regs/cur_acq; evt_gap<0 pulses the event during the trigger response
    task automatic run_job(input int evt_gap);
        redmule_ctrl_req_t exp_q[$];
        logic [7:0] exp_id = 8'h0;
        int nf = 0;
        int cyc;
        bit ok = 1'b0;
        for (int k = 0; k < cur_acq.size() && !ok && nf < MAX_RETRY; k++) begin
            exp_q.push_back(mk(32'h04, 32'h0, 1'b1));
            if ($signed(cur_acq[k]) >= 0) begin
                ok = 1'b1;
                exp_id = cur_acq[k][7:0];
            end else nf++;
        end
        if (ok) begin
            for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(mk(32'h40 + 32'(4 * i), cur_regs[i], 1'b0));
            exp_q.push_back(mk(32'h00, 32'h0, 1'b0));
        end
        log_q.delete();
        acq_q = cur_acq;
        checks++;
        if (job_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL ready_idle: ready=%b busy=%b, want ready=1 busy=0", job_ready_o, busy_o);
        else passes++;
        job_valid = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) job_regs[i] = cur_regs[i];
        @(negedge clk_i);
        job_valid = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) job_regs[i] = $urandom();
        checks++;
        if (ctrl_req.req !== 1'b1 || ctrl_req.add !== 32'h04 || ctrl_req.wen !== 1'b1)
            $display("FAIL first_req: req=%b add=%h wen=%b, want req=1 add=00000004 wen=1", ctrl_req.req, ctrl_req.add, ctrl_req.wen);
        else passes++;
        evt = noise_evt;
        @(negedge clk_i);
        evt = 1'b0;
        cyc = 0;
        if (!ok) begin
            while (err_o !== 1'b1 && cyc < 2000) begin
                @(negedge clk_i);
                cyc++;
            end
            checks++;
            if (err_o !== 1'b1) $display("FAIL err_pulse: err_o=%b, want 1", err_o);
            else passes++;
        end else if (evt_gap < 0) begin
            while (!(ctrl_req.req === 1'b1 && ctrl_req.add === 32'h00 && ctrl_req.wen === 1'b0) && cyc < 2000) begin
                @(negedge clk_i);
                cyc++;
            end
            @(negedge clk_i);
            evt = 1'b1;
            @(negedge clk_i);
            evt = 1'b0;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL early_wait: done=%b busy=%b, want done=0 busy=1", done_o, busy_o);
            else passes++;
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b1) $display("FAIL early_done: done=%b, want 1", done_o);
            else passes++;
        end else begin
            while (log_q.size() < exp_q.size() && cyc < 2000) begin
                @(negedge clk_i);
                cyc++;
            end
            repeat (evt_gap) @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL evt_wait: done=%b busy=%b, want done=0 busy=1", done_o, busy_o);
            else passes++;
            evt = 1'b1;
            @(negedge clk_i);
            evt = 1'b0;
            checks++;
            if (done_o !== 1'b1) $display("FAIL done_pulse: done=%b, want 1", done_o);
            else passes++;
        end
        if (ok) begin
            checks++;
            if (job_id_o !== exp_id) $display("FAIL job_id: got %h, want %h", job_id_o, exp_id);
            else passes++;
        end
        checks++;
        if (log_q.size() != exp_q.size()) $display("FAIL txn_count: got %0d, want %0d", log_q.size(), exp_q.size());
        else passes++;
        foreach (exp_q[k]) begin
            if (k < log_q.size()) begin
                checks++;
                if (log_q[k].add !== exp_q[k].add || log_q[k].wen !== exp_q[k].wen || log_q[k].be !== exp_q[k].be ||
                    log_q[k].id !== exp_q[k].id || (!exp_q[k].wen && log_q[k].data !== exp_q[k].data))
                    $display("FAIL txn[%0d]: got add=%h data=%h wen=%b be=%h id=%h, want add=%h data=%h wen=%b be=f id=00",
                             k, log_q[k].add, log_q[k].data, log_q[k].wen, log_q[k].be, log_q[k].id,
                             exp_q[k].add, exp_q[k].data, exp_q[k].wen);
                else passes++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if (ctrl_req !== '0) $display("FAIL rst_req: got %h, want 0", ctrl_req);
        else passes++;
        checks++;
        if (job_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL rst_ready: ready=%b busy=%b, want 1/0", job_ready_o, busy_o);
        else passes++;
        checks++;
        if (done_o !== 1'b0 || err_o !== 1'b0 || job_id_o !== 8'h0)
            $display("FAIL rst_flags: done=%b err=%b id=%h, want 0/0/00", done_o, err_o, job_id_o);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_nominal();
        gnt_max = 0; rv_min = 1; rv_max = 1;
        for (int i = 0; i < NUM_REGS; i++) cur_regs[i] = 32'h1000 + 32'(i);
        cur_acq = {32'h3};
        run_job(20);
        @(negedge clk_i);
    endtask

    task automatic test_acquire_retry();
        for (int i = 0; i < NUM_REGS; i++) cur_regs[i] = $urandom();
        cur_acq = {32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0};
        run_job(10);
        @(negedge clk_i);
    endtask

    task automatic test_acquire_fail();
        int d0 = done_cnt, e0 = err_cnt;
        cur_acq = {rnd_neg(), rnd_neg(), rnd_neg(), rnd_neg(), rnd_neg()};
        run_job(10);
        @(negedge clk_i);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0)
            $display("FAIL err_count: err=%0d done=%0d, want err=1 done=0", err_cnt - e0, done_cnt - d0);
        else passes++;
        checks++;
        if (job_ready_o !== 1'b1) $display("FAIL err_idle: ready=%b, want 1", job_ready_o);
        else passes++;
    endtask

    task automatic test_back_pressure();
        gnt_max = 5; rv_min = 1; rv_max = 4;
        noise_evt = 1'b1;
        repeat (4) begin
            for (int i = 0; i < NUM_REGS; i++) cur_regs[i] = $urandom();
            cur_acq.delete();
            repeat ($urandom_range(2, 0)) cur_acq.push_back(rnd_neg());
            cur_acq.push_back(rnd_pos());
            run_job(12);
            @(negedge clk_i);
        end
        noise_evt = 1'b0;
        gnt_max = 0; rv_min = 1; rv_max = 1;
    endtask

    task automatic test_early_event();
        int d0;
        for (int i = 0; i < NUM_REGS; i++) cur_regs[i] = $urandom();
        cur_acq = {rnd_pos()};
        run_job(-1);
        @(negedge clk_i);
        d0 = done_cnt;
        evt = 1'b1;
        @(negedge clk_i);
        evt = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if (done_cnt != d0 || busy_o !== 1'b0) $display("FAIL stray_evt: done pulses=%0d busy=%b, want 0/0", done_cnt - d0, busy_o);
        else passes++;
    endtask

    task automatic test_back_to_back();
        repeat (3) begin
            for (int i = 0; i < NUM_REGS; i++) cur_regs[i] = $urandom();
            cur_acq = {rnd_pos()};
            run_job(8);
            @(negedge clk_i);
        end
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        cur_acq = {32'h7};
        acq_q = cur_acq;
        job_valid = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) job_regs[i] = $urandom();
        @(negedge clk_i);
        job_valid = 1'b0;
        while (!(ctrl_req.req === 1'b1 && ctrl_req.add === 32'h50) && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        checks++;
        if (job_id_o !== 8'h07 || ctrl_req.add !== 32'h50) $display("FAIL pre_reset: id=%h add=%h, want 07/00000050", job_id_o, ctrl_req.add);
        else passes++;
        rst_n = 1'b0;
        @(posedge clk_i);
        #1;
        checks++;
        if (ctrl_req !== '0 || job_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || job_id_o !== 8'h0)
            $display("FAIL mid_reset: req=%h ready=%b busy=%b done=%b err=%b id=%h, want all reset values",
                     ctrl_req, job_ready_o, busy_o, done_o, err_o, job_id_o);
        else passes++;
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++;
        if (job_ready_o !== 1'b1 || ctrl_req.req !== 1'b0) $display("FAIL post_reset_idle: ready=%b req=%b, want 1/0", job_ready_o, ctrl_req.req);
        else passes++;
        for (int i = 0; i < NUM_REGS; i++) cur_regs[i] = $urandom();
        cur_acq = {rnd_pos()};
        run_job(10);
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_acquire_retry();
        test_acquire_fail();
        test_back_pressure();
        test_early_event();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/redmule_job_sequencer.md
# redmule_job_sequencer

Hardware job launcher for the RedMulE accelerator in the MAGIA tile. It accepts a complete job descriptor through a valid/ready port and acquires a RedMulE job slot over the HWPE-ctrl register port. It then writes the job registers, triggers execution, waits for the completion event and reports done with the acquired job ID. It takes the place of the core-driven OBI→HWPE-ctrl programming path when jobs are issued by tile hardware, such as the event unit or a command queue.

## Interface
Parameters:
- NUM_REGS, 8: number of job registers written per job, range 1..16.
- BASE_ADDR, 32'h0000_0000: RedMulE ctrl base address.
- MAX_ACQ_RETRY, 16: failed acquire reads tolerated before the error exit, range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low.
- job_valid_i  in  1  descriptor valid.
- job_ready_o  out  1  descriptor accepted when valid&ready.
- job_regs_i  in  NUM_REGS×32  register values. Entry i goes to offset 0x40+4i.
- ctrl_req_o  out  redmule_ctrl_req_t  HWPE-ctrl request: req, add, data, be, wen, id.
- ctrl_rsp_i  in  redmule_ctrl_rsp_t  HWPE-ctrl response: gnt, r_valid, r_data.
- evt_i  in  1  RedMulE job-done event, single-cycle pulse.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse on job completion.
- err_o  out  1  one-cycle pulse on acquire failure.
- job_id_o  out  8  acquired job ID, which is r_data[7:0] of the successful acquire read.

## Operation
- States: IDLE, ACQ_REQ, ACQ_RSP, WR_REQ, WR_RSP, TRIG_REQ, TRIG_RSP, WAIT_EVT, DONE, ERR.
- IDLE
  - job_ready_o=1.
  - On valid&ready the descriptor is latched into an internal register file, the retry counter and write index are cleared, and the FSM moves to ACQ_REQ.
  - job_regs_i is not sampled after the accept.
- ACQ_REQ: read of BASE+0x04 (ACQUIRE), wen=1, be=4'hF. Moves to ACQ_RSP on gnt.
- ACQ_RSP, on r_valid:
  - If r_data is signed ≥0: latch job_id_o and go to WR_REQ.
  - Otherwise increment the retry counter. If the counter equals MAX_ACQ_RETRY go to ERR, else go to ACQ_REQ.
- WR_REQ: write, wen=0, be=4'hF, add=BASE+0x40+4·idx, data=reg[idx]. Moves to WR_RSP on gnt.
- WR_RSP, on r_valid:
  - If idx==NUM_REGS-1 go to TRIG_REQ.
  - Otherwise increment idx and go to WR_REQ.
- TRIG_REQ: write 32'h0 to BASE+0x00 (TRIGGER). Moves to TRIG_RSP on gnt.
- TRIG_RSP → WAIT_EVT on r_valid.
- WAIT_EVT → DONE when the sticky event flag is set.
- DONE asserts done_o for one cycle, then returns to IDLE.
- ERR asserts err_o for one cycle, then returns to IDLE. No job registers are written on this path.
- Event flag
  - Cleared on job accept.
  - Set by evt_i in any cycle from the TRIG_REQ grant cycle onward.
  - evt_i in any other state is ignored.
- ctrl_req_o.id is always '0.
- r_data in write and trigger responses is ignored.

## Timing
- Reset values: ctrl_req_o all fields 0, job_ready_o=1, busy_o=0, done_o=0, err_o=0, job_id_o=0.
- Internal reset state: FSM=IDLE, idx=0, retry=0, event flag=0.
- Reset mid-transaction:
  - Takes effect at the next edge.
  - Any in-flight r_valid arriving after reset is dropped while in IDLE.
- Request handshake:
  - req rises in the first cycle of a *_REQ state.
  - add, data, wen and be are held constant until the gnt cycle.
  - req deasserts in the cycle after gnt.
  - At most one outstanding transaction.
- Response: r_valid may arrive in the gnt cycle+1 or later. It is accepted only in *_RSP states.
- Best-case latency, with gnt in the same cycle and r_valid one cycle later:
  - Accept → first request: 1 cycle.
  - Each transaction: 2 cycles.
  - Trigger gnt → done_o: event arrival + 1 cycle (through DONE).
- Back-to-back jobs: job_ready_o=1 the cycle after DONE. No bubble beyond the IDLE cycle.

## Structure
- The following belong in magia_tile_pkg:
  - RedMulE ctrl offsets: REDMULE_TRIGGER=0x00, REDMULE_ACQUIRE=0x04, REDMULE_JOB_BASE=0x40.
  - The FSM state enum redmule_seq_state_e.
  - The redmule_ctrl_req_t and redmule_ctrl_rsp_t types.
- Single module, no submodules. The register file and counters stay inline.

## Test plan
- Nominal job:
  - Stimulus: NUM_REGS=8, immediate gnt, r_valid one cycle later, acquire returns 3. job_regs=0x1000+i.
  - Expect: acquire read at 0x04, then writes 0x40..0x5C carrying 0x1000..0x1007, then a trigger write at 0x00.
  - Inject evt_i 20 cycles later. Expect done_o pulse and job_id_o=3.
- Acquire retry: acquire returns 0xFFFF_FFFE twice, then 0.
  - Expect three ACQUIRE reads, then normal completion with job_id_o=0.
- Acquire failure: MAX_ACQ_RETRY=4, acquire always negative.
  - Expect exactly 4 reads, err_o pulse, no write at ≥0x40, return to IDLE.
- Back-pressure: gnt delayed a random 0–5 cycles, r_valid delayed 1–4 cycles.
  - Expect add, data and wen stable while req&!gnt, and the identical write sequence.
- Early event: evt_i pulses in the TRIG_RSP cycle.
  - Expect done_o one cycle after entering WAIT_EVT. A stray evt_i in IDLE produces no done_o.
- Mid-job reset: rst_ni low during WR_REQ (idx=4).
  - Expect all outputs at reset values on the next edge, and a fresh job afterwards starting with an ACQUIRE read.
